// File: rtl/dpram_be.sv
// dpram_be: true dual-port RAM with byte-lane writes, read-during-write mode select
// and an optional output register with per-port read-valid flags.
module dpram_be #(
   parameter int size = 'h1000,
   parameter int addr_width = $clog2(size),
   parameter int data_width = 16,
   parameter int byte_width = 8,
   parameter bit read_new = 1'b0,
   parameter bit out_reg = 1'b0,
   localparam int nbytes = data_width / byte_width
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [addr_width-1:0] address_a,
   input  logic [data_width-1:0] data_a,
   input  logic [nbytes-1:0]     byteen_a,
   input  logic                  wren_a,
   input  logic                  cen_a,
   output logic [data_width-1:0] q_a,
   output logic                  qvalid_a,
   input  logic [addr_width-1:0] address_b,
   input  logic [data_width-1:0] data_b,
   input  logic [nbytes-1:0]     byteen_b,
   input  logic                  wren_b,
   input  logic                  cen_b,
   output logic [data_width-1:0] q_b,
   output logic                  qvalid_b
);
   localparam logic [addr_width:0] lim = (addr_width + 1)'(size);

   function automatic logic [data_width-1:0] lanes(input logic [nbytes-1:0] be);
      lanes = '0;
      for (int i = 0; i < nbytes; i++) lanes[i*byte_width +: byte_width] = {byte_width{be[i]}};
   endfunction

   logic [data_width-1:0] mem [size];
   logic in_a, in_b, wr_a, wr_b, same, wa, wb;
   logic [data_width-1:0] m_a, m_b, old_a, old_b, wd_a, wd_b, rd_a, rd_b;
   logic [data_width-1:0] q1_a_q, q1_a_d, q1_b_q, q1_b_d, q2_a_q, q2_a_d, q2_b_q, q2_b_d;
   logic v1_a_q, v1_a_d, v1_b_q, v1_b_d, v2_a_q, v2_a_d, v2_b_q, v2_b_d;

   always_comb begin
      in_a = {1'b0, address_a} < lim;
      in_b = {1'b0, address_b} < lim;
      wr_a = cen_a & wren_a & in_a;
      wr_b = cen_b & wren_b & in_b;
      same = address_a == address_b;
      m_a = lanes(wr_a ? byteen_a : '0);
      m_b = lanes(wr_b ? byteen_b : '0);
      old_a = in_a ? mem[address_a] : '0;
      old_b = in_b ? mem[address_b] : '0;
      wd_b = (old_b & ~m_b) | (data_b & m_b);
      // on a shared address port A writes the fully merged word, so its lanes win
      wd_a = ((same ? wd_b : old_a) & ~m_a) | (data_a & m_a);
      wa = wr_a & (|byteen_a);
      wb = wr_b & (|byteen_b) & ~(same & wa);
      rd_a = read_new ? (old_a & ~m_a) | (data_a & m_a) : old_a;
      rd_b = read_new ? (old_b & ~m_b) | (data_b & m_b) : old_b;
      q1_a_d = cen_a ? rd_a : q1_a_q;
      q1_b_d = cen_b ? rd_b : q1_b_q;
      v1_a_d = cen_a;
      v1_b_d = cen_b;
      q2_a_d = v1_a_q ? q1_a_q : q2_a_q;
      q2_b_d = v1_b_q ? q1_b_q : q2_b_q;
      v2_a_d = v1_a_q;
      v2_b_d = v1_b_q;
   end

   always_ff @(posedge clock) begin
      if (reset_n && wa) mem[address_a] <= wd_a;
      if (reset_n && wb) mem[address_b] <= wd_b;
   end

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         q1_a_q <= '0;
         q1_b_q <= '0;
         q2_a_q <= '0;
         q2_b_q <= '0;
         v1_a_q <= 1'b0;
         v1_b_q <= 1'b0;
         v2_a_q <= 1'b0;
         v2_b_q <= 1'b0;
      end else begin
         q1_a_q <= q1_a_d;
         q1_b_q <= q1_b_d;
         q2_a_q <= q2_a_d;
         q2_b_q <= q2_b_d;
         v1_a_q <= v1_a_d;
         v1_b_q <= v1_b_d;
         v2_a_q <= v2_a_d;
         v2_b_q <= v2_b_d;
      end

   assign q_a = out_reg ? q2_a_q : q1_a_q;
   assign q_b = out_reg ? q2_b_q : q1_b_q;
   assign qvalid_a = out_reg ? v2_a_q : v1_a_q;
   assign qvalid_b = out_reg ? v2_b_q : v1_b_q;
endmodule

// File: tb/tb_dpram_be.sv
// tb_dpram_be: two configurations (old-data/latency 1/power-of-two size and
// new-data/latency 2/size 100) driven in lockstep and compared with a word-level model.
module tb_dpram_be;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [6:0] adr [2];
   logic [15:0] dat [2];
   logic [1:0] be [2];
   logic we [2], ce [2];
   logic [15:0] qo [2][2];
   logic vo [2][2];
   int n_vec = 0, n_bad = 0;

   always #5 clk = ~clk;

   dpram_be #(.size(128), .read_new(1'b0), .out_reg(1'b0)) dut0 (
      .clock(clk), .reset_n(rst_n),
      .address_a(adr[0]), .data_a(dat[0]), .byteen_a(be[0]), .wren_a(we[0]), .cen_a(ce[0]),
      .q_a(qo[0][0]), .qvalid_a(vo[0][0]),
      .address_b(adr[1]), .data_b(dat[1]), .byteen_b(be[1]), .wren_b(we[1]), .cen_b(ce[1]),
      .q_b(qo[0][1]), .qvalid_b(vo[0][1]));

   dpram_be #(.size(100), .read_new(1'b1), .out_reg(1'b1)) dut1 (
      .clock(clk), .reset_n(rst_n),
      .address_a(adr[0]), .data_a(dat[0]), .byteen_a(be[0]), .wren_a(we[0]), .cen_a(ce[0]),
      .q_a(qo[1][0]), .qvalid_a(vo[1][0]),
      .address_b(adr[1]), .data_b(dat[1]), .byteen_b(be[1]), .wren_b(we[1]), .cen_b(ce[1]),
      .q_b(qo[1][1]), .qvalid_b(vo[1][1]));

   // model: word arrays with a "known" flag so uninitialised contents are never compared
   int sz [2] = '{128, 100};
   bit rn [2] = '{1'b0, 1'b1};
   int lat [2] = '{1, 2};
   logic [15:0] mm [2][128];
   bit kn [2][128];
   bit hv [2][2][2], hk [2][2][2], sk [2][2];
   logic [15:0] hd [2][2][2], sh [2][2];

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set(input int p, input bit c, input bit w, input logic [6:0] a,
                      input logic [15:0] d, input logic [1:0] b);
      ce[p] = c; we[p] = w; adr[p] = a; dat[p] = d; be[p] = b;
   endtask

   task automatic idle();
      set(0, 0, 0, 0, 0, 0);
      set(1, 0, 0, 0, 0, 0);
   endtask

   task automatic model_edge();
      logic [15:0] r;
      bit rk, inr;
      if (!rst_n) begin
         for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin
               sh[k][p] = '0; sk[k][p] = 1;
               for (int j = 0; j < 2; j++) begin hv[k][p][j] = 0; hd[k][p][j] = '0; hk[k][p][j] = 1; end
            end
         return;
      end
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < 2; p++) begin
            inr = int'(adr[p]) < sz[k];
            r = inr ? mm[k][adr[p]] : 16'h0;
            rk = inr ? kn[k][adr[p]] : 1'b1;
            if (rn[k] && ce[p] && we[p] && inr) begin
               for (int i = 0; i < 2; i++) if (be[p][i]) r[i*8 +: 8] = dat[p][i*8 +: 8];
               if (be[p] == 2'b11) rk = 1;
            end
            hv[k][p][1] = hv[k][p][0]; hd[k][p][1] = hd[k][p][0]; hk[k][p][1] = hk[k][p][0];
            hv[k][p][0] = ce[p]; hd[k][p][0] = r; hk[k][p][0] = rk;
         end
         for (int p = 1; p >= 0; p--)
            if (ce[p] && we[p] && int'(adr[p]) < sz[k]) begin
               for (int i = 0; i < 2; i++) if (be[p][i]) mm[k][adr[p]][i*8 +: 8] = dat[p][i*8 +: 8];
               if (be[p] == 2'b11) kn[k][adr[p]] = 1;
            end
         for (int p = 0; p < 2; p++)
            if (hv[k][p][lat[k]-1]) begin sh[k][p] = hd[k][p][lat[k]-1]; sk[k][p] = hk[k][p][lat[k]-1]; end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < 2; p++) begin
            check($sformatf("qvalid dut%0d port%0d", k, p), 16'(vo[k][p]), 16'(hv[k][p][lat[k]-1]));
            if (sk[k][p]) check($sformatf("q dut%0d port%0d", k, p), qo[k][p], sh[k][p]);
         end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) for (int a = 0; a < 128; a++) begin mm[k][a] = '0; kn[k][a] = 0; end
      idle();
      repeat (3) tick();
      rst_n = 1;
      for (int i = 0; i < 64; i++) begin
         set(0, 1, 1, 7'(i), 16'($urandom), 2'b11);
         set(1, 1, 1, 7'(i + 64), 16'($urandom), 2'b11);
         tick();
      end
      idle(); tick(); tick();
      rst_n = 0; repeat (3) tick();
      rst_n = 1;
      set(0, 1, 0, 5, 0, 0); tick();
      check("reset read lat1 valid", 16'(vo[0][0]), 1); check("reset read lat2 early", 16'(vo[1][0]), 0);
      idle(); tick();
      check("reset read lat2 valid", 16'(vo[1][0]), 1); check("reset read lat1 drop", 16'(vo[0][0]), 0);
      set(0, 1, 1, 'h10, 16'hABCD, 2'b11); tick();
      set(0, 1, 1, 'h10, 16'h1234, 2'b01); tick();
      idle(); set(1, 1, 0, 'h10, 0, 0); tick();
      idle(); tick();
      check("byte lanes dut0", qo[0][1], 16'hAB34); check("byte lanes dut1", qo[1][1], 16'hAB34);
      set(0, 1, 1, 'h20, 16'h1111, 2'b11); tick();
      set(0, 1, 1, 'h20, 16'h2222, 2'b10); tick();
      idle(); tick();
      check("rdw old", qo[0][0], 16'h1111); check("rdw new", qo[1][0], 16'h2211);
      set(0, 1, 1, 'h30, 16'h0F0F, 2'b11); tick();
      set(0, 1, 1, 'h30, 16'h5555, 2'b11); set(1, 1, 0, 'h30, 0, 0); tick();
      check("cross old dut0", qo[0][1], 16'h0F0F);
      set(0, 0, 0, 0, 0, 0); tick();
      check("cross next dut0", qo[0][1], 16'h5555); check("cross old dut1", qo[1][1], 16'h0F0F);
      idle(); tick();
      check("cross next dut1", qo[1][1], 16'h5555);
      set(0, 1, 1, 'h31, 16'hAAAA, 2'b01); set(1, 1, 1, 'h31, 16'hBBBB, 2'b11); tick();
      idle(); set(0, 1, 0, 'h31, 0, 0); tick();
      idle(); tick();
      check("dual write dut0", qo[0][0], 16'hBBAA); check("dual write dut1", qo[1][0], 16'hBBAA);
      for (int i = 1; i <= 4; i++) begin set(0, 1, 1, 7'(i), 16'(16'h0101 * i), 2'b11); tick(); end
      idle(); tick();
      set(0, 1, 0, 1, 0, 0); tick();
      check("gate v1", 16'(vo[0][0]), 1);
      set(0, 0, 1, 2, 16'hDEAD, 2'b11); tick();
      check("gate v2", 16'(vo[0][0]), 0); check("gate hold2", qo[0][0], 16'h0101);
      set(0, 0, 1, 3, 16'hDEAD, 2'b11); tick();
      check("gate v3", 16'(vo[0][0]), 0); check("gate hold3", qo[0][0], 16'h0101);
      set(0, 1, 0, 4, 0, 0); tick();
      check("gate v4", 16'(vo[0][0]), 1); check("gate q4", qo[0][0], 16'h0404);
      set(0, 1, 0, 2, 0, 0); tick();
      check("gate no write", qo[0][0], 16'h0202);
      set(0, 1, 1, 120, 16'h1234, 2'b11); tick();
      set(0, 1, 0, 120, 0, 0); tick();
      idle(); tick();
      check("range in dut0", qo[0][0], 16'h1234); check("range out dut1", qo[1][0], 16'h0000);
      check("range out valid", 16'(vo[1][0]), 1);
      set(0, 1, 1, 40, 16'h4040, 2'b11); tick();
      set(0, 1, 0, 40, 0, 0); tick();
      #2 rst_n = 0;
      #1;
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < 2; p++) begin
            check($sformatf("async q dut%0d port%0d", k, p), qo[k][p], 16'h0);
            check($sformatf("async v dut%0d port%0d", k, p), 16'(vo[k][p]), 16'h0);
         end
      set(0, 1, 1, 40, 16'hDEAD, 2'b11); tick();
      rst_n = 1;
      set(0, 1, 0, 40, 0, 0); tick();
      idle(); tick();
      check("reset no write dut0", qo[0][0], 16'h4040); check("reset no write dut1", qo[1][0], 16'h4040);
      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < 2; p++)
            set(p, 1'($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 9) == 0) ? 7'($urandom_range(96, 127)) : 7'($urandom_range(0, 7)),
                16'($urandom), 2'($urandom));
         rst_n = ($urandom_range(0, 59) != 0);
         tick();
      end
      rst_n = 1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
